// File: rtl/alu_pkg.sv
// Shared types for the iterative execute-stage ALU: operation codes,
// FSM states and a decode helper for the multi-cycle shift group.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SRA = 4'b0111,
    OP_SLT = 4'b1100,
    OP_EQ  = 4'b1000
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  // True for the ops that run through the bit-serial shifter.
  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath. Shift ops pass SrcA through unchanged, which
// is exactly the shift-by-zero result; longer shifts are finished by the top.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  illegal
);

  // Decode the op and form result/flags; EQ yields A^B so zero means equal.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_AND:                 result = a & b;
      OP_OR:                  result = a | b;
      OP_ADD:                 result = a + b;
      OP_SUB:                 result = a - b;
      OP_SLT:                 result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_EQ:                  result = a ^ b;
      OP_SLL, OP_SRL, OP_SRA: result = a;
      default:                illegal = 1'b1;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU with valid/ready handshake. Single-cycle ops finish the
// cycle after accept; shifts move one bit per cycle through an accumulator.
module alu_iter_exec
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero,
  output logic                  out_illegal
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  alu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, step_val, comb_result;
  logic [SHW-1:0]        cnt_q, shamt;
  logic [3:0]            op_q;
  logic                  zero_q, illegal_q, comb_zero, comb_illegal;

  assign shamt = in_b[SHW-1:0];

  alu_comb_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .op      (in_op),
    .a       (in_a),
    .b       (in_b),
    .result  (comb_result),
    .zero    (comb_zero),
    .illegal (comb_illegal)
  );

  // One-bit shift step of the accumulator for the latched shift op.
  always_comb begin
    step_val = acc_q;
    case (op_q)
      OP_SLL:  step_val = {acc_q[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  step_val = {1'b0, acc_q[DATA_WIDTH-1:1]};
      OP_SRA:  step_val = {acc_q[DATA_WIDTH-1], acc_q[DATA_WIDTH-1:1]};
      default: step_val = acc_q;
    endcase
  end

  // Next-state logic: accept in IDLE, count down in SHIFT, drain in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = (is_shift(in_op) && shamt != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt_q == CNT_ONE) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath: capture at accept, shift in SHIFT, hold everything in DONE.
  always_ff @(posedge clk) begin
    // NOTE: the in-flight operation is discarded on reset, so every datapath register is cleared.
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          acc_q     <= comb_result;
          cnt_q     <= shamt;
          op_q      <= in_op;
          zero_q    <= comb_zero;
          illegal_q <= comb_illegal;
        end
        SHIFT: begin
          acc_q <= step_val;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) zero_q <= (step_val == '0);
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_result  = acc_q;
  assign out_zero    = zero_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Self-checking bench for alu_iter_exec: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_alu_iter_exec;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_result;
  logic          out_zero;
  logic          out_illegal;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  alu_iter_exec #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: result, zero flag, illegal flag and cycles from accept to out_valid.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic z, output logic il,
                                output int lat);
    int n;
    n   = int'(b[4:0]);
    il  = 1'b0;
    lat = 1;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a + b;
      4'h6: r = a - b;
      4'h4: begin r = a << n; lat = 1 + n; end
      4'h5: begin r = a >> n; lat = 1 + n; end
      4'h7: begin r = $unsigned($signed(a) >>> n); lat = 1 + n; end
      4'hC: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h8: r = a ^ b;
      default: begin r = 32'd0; il = 1'b1; end
    endcase
    z = (op == 4'h8) ? (a == b) : (r == 32'd0);
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic        ez, eil;
    int          elat, lat;
    model(op, a, b, er, ez, eil, elat);
    check({tag, " ready_before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 4'($urandom); in_a = $urandom; in_b = $urandom;
    check({tag, " busy_after_accept"}, 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat <= DW + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " result"}, out_result, er);
    check({tag, " zero"}, 32'(out_zero), 32'(ez));
    check({tag, " illegal"}, 32'(out_illegal), 32'(eil));
    repeat (hold) begin
      @(posedge clk); #1;
      check({tag, " held_valid"}, 32'(out_valid), 32'd1);
      check({tag, " held_ready"}, 32'(in_ready), 32'd0);
      check({tag, " held_result"}, out_result, er);
      check({tag, " held_zero"}, 32'(out_zero), 32'(ez));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " ready_after_handshake"}, 32'(in_ready), 32'd1);
    check({tag, " valid_after_handshake"}, 32'(out_valid), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    check({tag, " out_result"}, out_result, 32'd0);
    check({tag, " out_zero"}, 32'(out_zero), 32'd0);
    check({tag, " out_illegal"}, 32'(out_illegal), 32'd0);
  endtask

  initial begin
    logic [3:0]  codes [12];
    logic [3:0]  op;
    logic [31:0] a, b;
    codes = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h4, 4'h5, 4'h7, 4'hC, 4'h8, 4'h3, 4'h9, 4'hF};

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;

    // Directed single-cycle ops
    run_op("add", 4'h2, 32'd5, 32'd7, 0);
    run_op("sub_zero", 4'h6, 32'd3, 32'd3, 0);
    run_op("slt_neg", 4'hC, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("slt_pos", 4'hC, 32'd1, 32'hFFFF_FFFF, 0);
    run_op("eq_same", 4'h8, 32'h1234, 32'h1234, 0);
    run_op("eq_diff", 4'h8, 32'h1234, 32'h1235, 0);
    run_op("and", 4'h0, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    run_op("or", 4'h1, 32'hF000_0001, 32'h0000_1000, 0);

    // Directed shifts including shift-by-zero and the maximum amount
    run_op("sra4", 4'h7, 32'h8000_0000, 32'd4, 0);
    run_op("srl4", 4'h5, 32'h8000_0000, 32'd4, 0);
    run_op("sll31", 4'h4, 32'd1, 32'd31, 0);
    run_op("sll0", 4'h4, 32'hDEAD_BEEF, 32'h20, 0);
    run_op("srl_to_zero", 4'h5, 32'd1, 32'd1, 0);

    // Backpressure and illegal op
    run_op("add_backpressure", 4'h2, 32'h7FFF_FFFF, 32'd1, 3);
    run_op("illegal", 4'h3, 32'h1111_1111, 32'h2222_2222, 1);

    // Reset in the middle of a long SRA
    in_valid = 1'b1; in_op = 4'h7; in_a = 32'h8000_0000; in_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_state("reset_mid_shift");
    rst_n = 1'b1;

    // Reset while a result is pending
    in_valid = 1'b1; in_op = 4'h2; in_a = 32'd9; in_b = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_state("reset_mid_done");
    rst_n = 1'b1;

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      op = codes[$urandom_range(0, 11)];
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 1) == 0) b = b & 32'h0000_0007;
      run_op($sformatf("rand%0d_op%h", i, op), op, a, b, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
Execute-stage ALU that consumes the 4-bit Operation code produced by the ALU controller and returns a registered result over a valid/ready handshake.
- Arithmetic, logic, compare and equality ops complete in one cycle.
- Shifts run iteratively, one bit per cycle, to save area.
- Sits between ID/EX operand registers and EX/MEM writeback/branch logic; the pipeline stalls on in_ready/out_valid.

Parameters:
DATA_WIDTH, 32, operand/result width; shift amount width SHW = $clog2(DATA_WIDTH) is a derived localparam.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operation request present
in_ready  out  1  unit can accept a request
in_op  in  4  Operation code from the ALU controller
in_a  in  DATA_WIDTH  SrcA
in_b  in  DATA_WIDTH  SrcB (shift amount = in_b[SHW-1:0])
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_result  out  DATA_WIDTH  result
out_zero  out  1  result == 0 (for EQ: operands equal)
out_illegal  out  1  in_op not in the decoded set

Behaviour:
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
  - 0100 SLL, 0101 SRL, 0111 SRA
  - 1100 SLT (signed, result 1/0)
  - 1000 EQ: result = A^B, out_zero = (A==B), used for branches
  - Any other code is illegal: result 0, out_zero 1, out_illegal 1, single-cycle latency.
- Arithmetic is modulo 2^DATA_WIDTH. Overflow is ignored and no flag is produced.
- States: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- Accept happens on in_valid && in_ready, call this cycle T.
  - Non-shift op: result and flags registered; IDLE->DONE; out_valid high at T+1.
  - Shift with n = in_b[SHW-1:0]:
    - n==0: result = in_a, IDLE->DONE, out_valid at T+1.
    - n>0: accumulator <= in_a, counter <= n, IDLE->SHIFT. Each SHIFT cycle shifts the accumulator by 1 (SRA replicates the MSB) and decrements the counter. At counter==1 the cycle ends with SHIFT->DONE. out_valid at T+1+n; total latency 1+n cycles, max DATA_WIDTH.
- DONE: out_result, out_zero and out_illegal are held stable while out_valid && !out_ready. On out_ready, DONE->IDLE; in_ready is high the following cycle. There is no back-to-back accept in the handshake cycle.
- in_op, in_a and in_b are sampled only at accept. Changes at any other time are ignored.
- Reset, including mid-SHIFT or mid-DONE: state IDLE, out_valid 0, out_result 0, out_zero 0, out_illegal 0, counter 0. The in-flight operation is discarded.
- in_valid while not ready: the request is not consumed, and the requester must hold it.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [3:0] alu_op_e with the codes above.
  - typedef enum alu_state_e {IDLE, SHIFT, DONE}.
  - Function is_shift(op).
- Sub-module alu_comb_core: purely combinational single-cycle ops (AND/OR/ADD/SUB/SLT/EQ/illegal → result, zero, illegal).
- The top level owns the FSM, the shift accumulator and counter, and the output registers.

Test Plan:
- ADD: a=5, b=7, op 0010 accepted at T -> out_valid at T+1, result 12, zero 0. SUB: a=b=3, op 0110 -> result 0, zero 1.
- SLT: a=0xFFFFFFFF, b=1, op 1100 -> result 1. EQ: a=b=0x1234, op 1000 -> zero 1; a=0x1234, b=0x1235 -> zero 0.
- SRA: a=0x80000000, b=4, op 0111 -> in_ready low T+1..T+5, out_valid at T+5, result 0xF8000000. SRL same operands -> 0x08000000. SLL a=1, b=31 -> 0x80000000 at T+32.
- Shift by 0: SLL a=0xDEADBEEF, b=0x20 (shamt 0) -> result 0xDEADBEEF at T+1.
- Backpressure: ADD result pending, out_ready low 3 cycles -> out_result/out_zero stable, in_ready low; out_ready high -> in_ready high next cycle.
- Illegal op 0011 -> out_illegal 1, result 0, T+1. rst_n low during SRA by 20 at T+5 -> next cycle out_valid 0, in_ready 1, outputs 0.
